// File: rtl/ghost_mode_ctrl.sv
// Global scatter/chase/frightened sequencer with reverse pulse for all ghosts.
// Optional end-of-frightened flash output: define FRIGHT_FLASH_EN.
module ghost_mode_ctrl #(
  parameter int CLK_HZ     = 25_000_000,
  parameter int SCAT1_SEC  = 7,
  parameter int SCAT2_SEC  = 5,
  parameter int CHASE_SEC  = 20,
  parameter int FRIGHT_SEC = 6
`ifdef FRIGHT_FLASH_EN
  ,
  parameter int FLASH_SEC  = 2
`endif
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       game_start,
  input  logic       pause,
  input  logic       power_pellet,
  output logic       isScatter,
  output logic       isChase,
  output logic       isFrightened,
  output logic       reverse,
  output logic [2:0] phase,
  output logic       fright_flash
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [4:0] FR_LAST = 5'(FRIGHT_SEC - 1);
  localparam logic [4:0] S1_LAST = 5'(SCAT1_SEC - 1);
  localparam logic [4:0] S2_LAST = 5'(SCAT2_SEC - 1);
  localparam logic [4:0] CH_LAST = 5'(CHASE_SEC - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCATTER,
    CHASE,
    FRIGHT
  } state_t;

  state_t          r_state;
  state_t          w_nstate;
  logic [2:0]      r_phase;
  logic [2:0]      w_nphase;
  logic [4:0]      r_sec;
  logic [4:0]      w_nsec;
  logic [4:0]      r_fr;
  logic [4:0]      w_nfr;
  logic [PW-1:0]   r_pre;
  logic [PW-1:0]   w_npre;
  logic            w_nrev;
  logic            w_run;
  logic            w_tick;
  logic [4:0]      w_last;
  logic            r_scat;
  logic            r_chase;
  logic            r_fright;
  logic            r_rev;

  assign w_run  = (r_state != IDLE) && !pause;
  assign w_tick = w_run && (r_pre == PRE_MAX);

  always_comb begin
    w_last = CH_LAST;
    unique case (1'b1)
      (r_phase == 3'd0) || (r_phase == 3'd2): w_last = S1_LAST;
      (r_phase == 3'd4) || (r_phase == 3'd6): w_last = S2_LAST;
      default:                                w_last = CH_LAST;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    w_nphase = r_phase;
    w_nsec   = r_sec;
    w_nfr    = r_fr;
    w_nrev   = 1'b0;
    if (w_tick)     w_npre = '0;
    else if (w_run) w_npre = r_pre + PW'(1);
    else            w_npre = r_pre;

    if (game_start) begin
      w_nstate = SCATTER;
      w_nphase = 3'd0;
      w_nsec   = 5'd0;
      w_nfr    = 5'd0;
      w_npre   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          w_npre = '0;
        end
        SCATTER, CHASE: begin
          // phase 7 is endless chase: counters stop there
          if (w_tick && (r_phase != 3'd7)) begin
            if (r_sec == w_last) begin
              w_nphase = r_phase + 3'd1;
              w_nsec   = 5'd0;
              w_nstate = (r_state == SCATTER) ? CHASE : SCATTER;
              w_nrev   = 1'b1;
              w_npre   = '0;
            end else begin
              w_nsec = r_sec + 5'd1;
            end
          end
          if (power_pellet) begin
            w_nstate = FRIGHT;
            w_nfr    = 5'd0;
            w_nrev   = 1'b1;
            w_npre   = '0;
          end
        end
        FRIGHT: begin
          if (power_pellet) begin
            w_nfr  = 5'd0;
            w_npre = '0;
          end else if (w_tick) begin
            if (r_fr == FR_LAST) begin
              w_nstate = r_phase[0] ? CHASE : SCATTER;
              w_nfr    = 5'd0;
              w_npre   = '0;
            end else begin
              w_nfr = r_fr + 5'd1;
            end
          end
        end
        default: begin
          w_nstate = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_phase  <= 3'd0;
      r_sec    <= 5'd0;
      r_fr     <= 5'd0;
      r_pre    <= '0;
      r_scat   <= 1'b0;
      r_chase  <= 1'b0;
      r_fright <= 1'b0;
      r_rev    <= 1'b0;
    end else begin
      r_state  <= w_nstate;
      r_phase  <= w_nphase;
      r_sec    <= w_nsec;
      r_fr     <= w_nfr;
      r_pre    <= w_npre;
      r_scat   <= (w_nstate == SCATTER);
      r_chase  <= (w_nstate == CHASE);
      r_fright <= (w_nstate == FRIGHT);
      r_rev    <= w_nrev;
    end
  end

  assign isScatter    = r_scat;
  assign isChase      = r_chase;
  assign isFrightened = r_fright;
  assign reverse      = r_rev;
  assign phase        = r_phase;

`ifdef FRIGHT_FLASH_EN
  localparam logic [4:0] FL_TH = 5'(FRIGHT_SEC - FLASH_SEC);
  logic r_flash;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_flash <= 1'b0;
    else          r_flash <= (w_nstate == FRIGHT) && (w_nfr >= FL_TH);
  end

  assign fright_flash = r_flash;
`else
  assign fright_flash = 1'b0;
`endif

endmodule

// File: tb/tb_ghost_mode_ctrl.sv
// Directed bench for ghost_mode_ctrl at CLK_HZ=4 (one second = 4 cycles).
// Flash expectations follow FRIGHT_FLASH_EN.
module tb_ghost_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       game_start;
  logic       pause;
  logic       power_pellet;
  logic       isScatter;
  logic       isChase;
  logic       isFrightened;
  logic       reverse;
  logic [2:0] phase;
  logic       fright_flash;

  int total = 0;
  int bad   = 0;

`ifdef FRIGHT_FLASH_EN
  localparam logic FL_ON = 1'b1;
`else
  localparam logic FL_ON = 1'b0;
`endif

  ghost_mode_ctrl #(.CLK_HZ(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .game_start   (game_start),
    .pause        (pause),
    .power_pellet (power_pellet),
    .isScatter    (isScatter),
    .isChase      (isChase),
    .isFrightened (isFrightened),
    .reverse      (reverse),
    .phase        (phase),
    .fright_flash (fright_flash)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    game_start = 1'b1;
    step(1);
    game_start = 1'b0;
  endtask

  task automatic pellet_pulse();
    power_pellet = 1'b1;
    step(1);
    power_pellet = 1'b0;
  endtask

  task automatic mode(input string tag, input logic s, input logic c,
                      input logic f, input logic [2:0] p);
    chk({tag, ".scat"}, 32'(isScatter), 32'(s));
    chk({tag, ".chase"}, 32'(isChase), 32'(c));
    chk({tag, ".fright"}, 32'(isFrightened), 32'(f));
    chk({tag, ".phase"}, 32'(phase), 32'(p));
  endtask

  int exp_d[7] = '{28, 80, 28, 80, 20, 80, 20};
  int revs;
  int last;
  logic [2:0] prev;

  initial begin
    reset_n      = 1'b1;
    game_start   = 1'b0;
    pause        = 1'b0;
    power_pellet = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    mode("rst", 0, 0, 0, 3'd0);
    chk("rst.rev", 32'(reverse), 0);
    chk("rst.flash", 32'(fright_flash), 0);
    step(2);
    reset_n = 1'b1;
    step(5);
    pellet_pulse();
    mode("idle_pp", 0, 0, 0, 3'd0);
    chk("idle_pp.rev", 32'(reverse), 0);
    step(2);

    start_pulse();
    mode("start", 1, 0, 0, 3'd0);
    chk("start.rev", 32'(reverse), 0);
    step(27);
    mode("s0_end", 1, 0, 0, 3'd0);
    chk("s0_end.rev", 32'(reverse), 0);
    step(1);
    mode("p1", 0, 1, 0, 3'd1);
    chk("p1.rev", 32'(reverse), 1);
    step(1);
    chk("p1.rev_off", 32'(reverse), 0);

    step(39);
    pellet_pulse();
    mode("fr1", 0, 0, 1, 3'd1);
    chk("fr1.rev", 32'(reverse), 1);
    step(1);
    chk("fr1.rev_off", 32'(reverse), 0);
    step(22);
    mode("fr1_end", 0, 0, 1, 3'd1);
    step(1);
    mode("fr1_exit", 0, 1, 0, 3'd1);
    chk("fr1_exit.rev", 32'(reverse), 0);
    step(39);
    mode("p1_resume", 0, 1, 0, 3'd1);
    step(1);
    mode("p2", 1, 0, 0, 3'd2);
    chk("p2.rev", 32'(reverse), 1);

    step(1);
    pellet_pulse();
    mode("fr2", 0, 0, 1, 3'd2);
    chk("fr2.rev", 32'(reverse), 1);
    chk("fr2.flash", 32'(fright_flash), 0);
    step(12);
    pellet_pulse();
    mode("rearm", 0, 0, 1, 3'd2);
    chk("rearm.rev", 32'(reverse), 0);
    step(15);
    chk("rearm.flash_pre", 32'(fright_flash), 0);
    step(1);
    chk("rearm.flash_on", 32'(fright_flash), 32'(FL_ON));
    step(7);
    mode("rearm_end", 0, 0, 1, 3'd2);
    chk("rearm_end.flash", 32'(fright_flash), 32'(FL_ON));
    step(1);
    mode("fr2_exit", 1, 0, 0, 3'd2);
    chk("fr2_exit.flash", 32'(fright_flash), 0);
    chk("fr2_exit.rev", 32'(reverse), 0);

    step(4);
    pause = 1'b1;
    step(100);
    mode("pause", 1, 0, 0, 3'd2);
    chk("pause.rev", 32'(reverse), 0);
    pause = 1'b0;
    step(23);
    mode("unpause", 1, 0, 0, 3'd2);
    step(1);
    mode("p3", 0, 1, 0, 3'd3);
    chk("p3.rev", 32'(reverse), 1);

    start_pulse();
    mode("sched0", 1, 0, 0, 3'd0);
    revs = 0;
    last = 0;
    prev = 3'd0;
    for (int i = 1; i <= 1300; i++) begin
      step(1);
      if (reverse) revs++;
      if (phase != prev) begin
        chk($sformatf("dur%0d", prev), 32'(i - last), 32'(exp_d[prev]));
        last = i;
        prev = phase;
      end
    end
    mode("sched_end", 0, 1, 0, 3'd7);
    chk("sched.revs", 32'(revs), 7);

    game_start   = 1'b1;
    power_pellet = 1'b1;
    step(1);
    game_start   = 1'b0;
    power_pellet = 1'b0;
    mode("gs_pp", 1, 0, 0, 3'd0);
    chk("gs_pp.rev", 32'(reverse), 0);

    step(27);
    pellet_pulse();
    mode("exp_pp", 0, 0, 1, 3'd1);
    chk("exp_pp.rev", 32'(reverse), 1);
    step(1);
    chk("exp_pp.rev_off", 32'(reverse), 0);
    step(22);
    mode("exp_pp_fr", 0, 0, 1, 3'd1);
    step(1);
    mode("exp_pp_exit", 0, 1, 0, 3'd1);

    pellet_pulse();
    step(3);
    #2 reset_n = 1'b0;
    #1;
    mode("arst", 0, 0, 0, 3'd0);
    chk("arst.rev", 32'(reverse), 0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    step(2);
    pellet_pulse();
    mode("arst_pp", 0, 0, 0, 3'd0);
    step(5);
    mode("arst_idle", 0, 0, 0, 3'd0);
    start_pulse();
    mode("arst_start", 1, 0, 0, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ghost_mode_ctrl.md
Name: ghost_mode_ctrl

Overview:
- Global scatter/chase/frightened mode sequencer for all ghosts.
- Drives isChase/isScatter into every ghost movement block (blinky and siblings).
- Provides a one-cycle reverse pulse whenever ghosts must turn around.
- Runs the level-1 arcade schedule from a 1-second tick derived from the 25 MHz system clock; power pellets suspend the schedule for a frightened interval.

Parameters:
- CLK_HZ, 25_000_000, system clock frequency; prescaler wraps at CLK_HZ-1.
- SCAT1_SEC, 7, duration of scatter phases 0 and 2, in seconds.
- SCAT2_SEC, 5, duration of scatter phases 4 and 6, in seconds.
- CHASE_SEC, 20, duration of chase phases 1, 3 and 5, in seconds.
- FRIGHT_SEC, 6, frightened duration in seconds.
- FLASH_SEC, 2, length of the flash window at the end of frightened (optional feature only).

Ports:
- clk  input  1  system clock, 25 MHz.
- reset_n  input  1  asynchronous, active-low reset.
- game_start  input  1  one-cycle pulse; (re)starts the schedule at phase 0.
- pause  input  1  level; while high, the prescaler and all timers hold.
- power_pellet  input  1  one-cycle pulse; enters or re-arms frightened.
- isScatter  output  1  ghosts target their corners.
- isChase  output  1  ghosts target per-ghost chase tiles.
- isFrightened  output  1  frightened mode active.
- reverse  output  1  one-cycle pulse requesting all ghosts to reverse direction.
- phase  output  3  current schedule phase, 0..7.
- fright_flash  output  1  end-of-frightened warning (see Optional Feature).

Behaviour:
- All outputs are registered. Each output changes on the clock edge after the triggering input or tick.
- Reset values: state=IDLE, all mode outputs 0, reverse=0, phase=0, prescaler=0, sec_cnt=0, fright_cnt=0, fright_flash=0.
- Prescaler: counts 0..CLK_HZ-1 when not paused and state is not IDLE. sec_tick is high for the one cycle in which it wraps. The prescaler clears on every state entry.
- States:
  - IDLE: isChase=isScatter=isFrightened=0.
  - SCATTER (even phases): isScatter=1.
  - CHASE (odd phases): isChase=1.
  - FRIGHT: isFrightened=1, isChase=isScatter=0. phase and sec_cnt are frozen.
- Exactly one of isChase/isScatter/isFrightened is high outside IDLE.
- Schedule: S7, C20, S7, C20, S5, C20, S5, then phase 7 = chase with no end.
  - sec_cnt increments on sec_tick.
  - When sec_cnt reaches the phase duration and sec_tick fires: phase+1, sec_cnt=0, toggle SCATTER/CHASE, reverse=1 for one cycle.
  - In phase 7 nothing advances; phase saturates at 7.
- game_start from any state: next cycle SCATTER, phase=0, sec_cnt=0, fright_cnt=0, prescaler=0, reverse=0.
- power_pellet in SCATTER or CHASE: next cycle FRIGHT, fright_cnt=0, reverse=1.
- power_pellet in FRIGHT: fright_cnt reloads to 0 and the prescaler clears; no reverse pulse.
- power_pellet in IDLE: ignored.
- FRIGHT exit: when fright_cnt reaches FRIGHT_SEC on sec_tick, return to SCATTER if phase is even, CHASE if odd. The saved sec_cnt resumes. No reverse pulse.
- Simultaneous events:
  - game_start beats power_pellet, and both beat timer expiry.
  - power_pellet in the same cycle as a phase expiry: the phase advance is applied first, then FRIGHT is entered. A single reverse pulse is produced.
- pause: freezes the prescaler, sec_cnt and fright_cnt. Mode outputs hold. power_pellet and game_start are still accepted while paused; their new state's timers are frozen until pause drops.
- Width: sec_cnt and fright_cnt are 5 bits. The prescaler is $clog2(CLK_HZ) bits.
- reset_n asserted mid-operation returns everything to reset values immediately (asynchronous).

Optional Feature:
- Macro FRIGHT_FLASH_EN.
- Defined: fright_flash=1 while in FRIGHT and fright_cnt >= FRIGHT_SEC-FLASH_SEC. It clears on FRIGHT exit and on re-arm.
- Undefined: fright_flash is tied to 0 and no comparator logic is built.

Test Plan:
- CLK_HZ=4, reset_n low→high, game_start at cycle 10 → isScatter=1 and phase=0 at cycle 11; at 28 cycles after start, phase=1, isChase=1, reverse pulses for exactly one cycle.
- CLK_HZ=4, run 300+ s-equivalent (1200+ cycles) → phase sequence 0..7 with durations 7,20,7,20,5,20,5; phase stays 7 with isChase=1; 7 reverse pulses total.
- CLK_HZ=4, power_pellet during phase 1 at sec_cnt=10 → isFrightened=1, reverse pulse; after 24 cycles, isChase=1 again and phase 1 ends 10 s (40 cycles) later.
- CLK_HZ=4, second power_pellet 3 s into FRIGHT → FRIGHT lasts 6 s from the second pulse; no second reverse pulse. With FRIGHT_FLASH_EN defined, fright_flash=1 only during the last 8 cycles.
- CLK_HZ=4, pause high for 100 cycles during SCATTER → outputs and phase unchanged; remaining time resumes exactly after pause falls.
- reset_n pulsed low mid-FRIGHT → all outputs 0 at once; power_pellet afterwards (IDLE) ignored until game_start.
